// File: rtl/eth_mac_mmio.sv
// rtl/eth_mac_mmio.sv - memory-mapped Ethernet frame controller with 4-bit nibble link
// Host-side TX/RX byte buffers and registers; preamble/SFD framing on a single-clock SDR link.
module eth_mac_mmio #(
  parameter int buf_size_p       = 2048,
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [reg_addr_width_p-1:0] addr_i,
  input  logic                        write_en_i,
  input  logic                        read_en_i,
  input  logic [1:0]                  op_size_i,
  input  logic [data_width_p-1:0]     write_data_i,
  output logic [data_width_p-1:0]     read_data_o,
  output logic                        rx_interrupt_pending_o,
  output logic                        tx_interrupt_pending_o,
  input  logic [3:0]                  rxd_i,
  input  logic                        rx_ctl_i,
  output logic [3:0]                  txd_o,
  output logic                        tx_ctl_o
);
  localparam int size_width_lp = $clog2(buf_size_p) + 1;
  localparam int off_width_lp  = $clog2(buf_size_p);
  localparam int cnt_width_lp  = size_width_lp + 1;
  localparam int words_lp      = buf_size_p / 4;
  localparam int region_w_lp   = reg_addr_width_p - off_width_lp;

  localparam logic [reg_addr_width_p-1:0] rx_size_addr_lp  = reg_addr_width_p'(16'h1004);
  localparam logic [reg_addr_width_p-1:0] rx_drop_addr_lp  = reg_addr_width_p'(16'h1008);
  localparam logic [reg_addr_width_p-1:0] rx_pend_addr_lp  = reg_addr_width_p'(16'h1010);
  localparam logic [reg_addr_width_p-1:0] rx_inten_addr_lp = reg_addr_width_p'(16'h1014);
  localparam logic [reg_addr_width_p-1:0] tx_send_addr_lp  = reg_addr_width_p'(16'h1018);
  localparam logic [reg_addr_width_p-1:0] tx_rdy_addr_lp   = reg_addr_width_p'(16'h101C);
  localparam logic [reg_addr_width_p-1:0] tx_size_addr_lp  = reg_addr_width_p'(16'h1028);
  localparam logic [reg_addr_width_p-1:0] tx_pend_addr_lp  = reg_addr_width_p'(16'h1030);
  localparam logic [reg_addr_width_p-1:0] tx_inten_addr_lp = reg_addr_width_p'(16'h1034);

  typedef enum logic [1:0] {TX_IDLE, TX_PRE, TX_DATA, TX_GAP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA, RX_DROP} rx_state_e;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [31:0] m);
    return (old_v & ~m) | (wd & m);
  endfunction

  logic [31:0] tx_mem [words_lp];
  logic [31:0] rx_mem [words_lp];

  tx_state_e                 tx_state_q, tx_state_d;
  rx_state_e                 rx_state_q, rx_state_d;
  logic [cnt_width_lp-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [size_width_lp-1:0]  tx_len_q, tx_len_d, tx_size_q, tx_size_d, rx_size_q, rx_size_d;
  logic [15:0]               rx_drop_q, rx_drop_d;
  logic [3:0]                rx_lo_q, rx_lo_d;
  logic                      rx_pend_q, rx_pend_d, rx_inten_q, rx_inten_d;
  logic                      tx_pend_q, tx_pend_d, tx_inten_q, tx_inten_d;
  logic [data_width_p-1:0]   read_data_q, read_data_d;

  logic                        aligned, host_wr, in_rx, in_tx, send_req, w1c;
  logic [3:0]                  be;
  logic [31:0]                 wshift, wmask, size_mask, rd_word, rd_data, tmp_size, tmp_en;
  logic [reg_addr_width_p-1:0] reg_word;
  logic [region_w_lp-1:0]      region;
  logic [cnt_width_lp-1:0]     tx_last;
  logic [31:0]                 tx_word;
  logic [7:0]                  tx_byte, rx_byte;
  logic                        rx_we;
  logic [off_width_lp-1:0]     rx_off;

  // Host access decode: alignment, byte lanes and region select.
  always_comb begin
    aligned   = 1'b0;
    be        = 4'b0000;
    size_mask = 32'h0;
    case (op_size_i)
      2'd0: begin aligned = 1'b1;                be = 4'b0001 << addr_i[1:0]; size_mask = 32'h0000_00FF; end
      2'd1: begin aligned = ~addr_i[0];          be = 4'b0011 << addr_i[1:0]; size_mask = 32'h0000_FFFF; end
      2'd2: begin aligned = (addr_i[1:0] == 2'b00); be = 4'b1111;              size_mask = 32'hFFFF_FFFF; end
      default: ;
    endcase
    wshift   = 32'(write_data_i) << {addr_i[1:0], 3'b000};
    wmask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    host_wr  = write_en_i & aligned;
    region   = addr_i[reg_addr_width_p-1:off_width_lp];
    in_rx    = (region == '0);
    in_tx    = (region == region_w_lp'(1));
    reg_word = {addr_i[reg_addr_width_p-1:2], 2'b00};
    send_req = host_wr && !in_rx && !in_tx && (reg_word == tx_send_addr_lp);
    w1c      = wshift[0] & be[0];
  end

  always_comb begin
    rd_word = 32'h0;
    if (in_rx) begin
      rd_word = rx_mem[addr_i[off_width_lp-1:2]];
    end else if (!in_tx) begin
      case (reg_word)
        rx_size_addr_lp:  rd_word = 32'(rx_size_q);
        rx_drop_addr_lp:  rd_word = 32'(rx_drop_q);
        rx_pend_addr_lp:  rd_word = 32'(rx_pend_q);
        rx_inten_addr_lp: rd_word = 32'(rx_inten_q);
        tx_rdy_addr_lp:   rd_word = 32'(tx_state_q == TX_IDLE);
        tx_size_addr_lp:  rd_word = 32'(tx_size_q);
        tx_pend_addr_lp:  rd_word = 32'(tx_pend_q);
        tx_inten_addr_lp: rd_word = 32'(tx_inten_q);
        default:          rd_word = 32'h0;
      endcase
    end
    rd_data     = aligned ? ((rd_word >> {addr_i[1:0], 3'b000}) & size_mask) : 32'h0;
    read_data_d = read_en_i ? data_width_p'(rd_data) : read_data_q;
  end

  // TX serializer: 15 nibbles of 0x5, one 0xD, then payload low nibble first.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_len_d   = tx_len_q;
    tx_last    = {tx_len_q, 1'b0} - cnt_width_lp'(1);
    tx_word    = tx_mem[tx_cnt_q[off_width_lp:3]];
    tx_byte    = tx_word[{tx_cnt_q[2:1], 3'b000} +: 8];
    txd_o      = 4'h0;
    tx_ctl_o   = 1'b0;
    tx_pend_d  = tx_pend_q;
    if (host_wr && !in_rx && !in_tx && reg_word == tx_pend_addr_lp && w1c) tx_pend_d = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_req && tx_size_q != '0 && tx_size_q <= size_width_lp'(buf_size_p)) begin
          tx_state_d = TX_PRE;
          tx_cnt_d   = '0;
          tx_len_d   = tx_size_q;
        end
      end
      TX_PRE: begin
        tx_ctl_o = 1'b1;
        txd_o    = (tx_cnt_q == cnt_width_lp'(15)) ? 4'hD : 4'h5;
        if (tx_cnt_q == cnt_width_lp'(15)) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        tx_ctl_o = 1'b1;
        txd_o    = tx_cnt_q[0] ? tx_byte[7:4] : tx_byte[3:0];
        if (tx_cnt_q == tx_last) begin
          tx_state_d = TX_GAP;
          tx_cnt_d   = '0;
          tx_pend_d  = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (tx_cnt_q == cnt_width_lp'(23)) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // RX deframer; rx_cnt counts payload nibbles, a byte is written on each odd nibble.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_lo_d    = rx_lo_q;
    rx_size_d  = rx_size_q;
    rx_drop_d  = rx_drop_q;
    rx_we      = 1'b0;
    rx_off     = rx_cnt_q[off_width_lp:1];
    rx_byte    = {rxd_i, rx_lo_q};
    rx_pend_d  = rx_pend_q;
    if (host_wr && !in_rx && !in_tx && reg_word == rx_pend_addr_lp && w1c) rx_pend_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_ctl_i) begin
          if (rx_pend_q) begin
            rx_state_d = RX_DROP;
            if (rx_drop_q != 16'hFFFF) rx_drop_d = rx_drop_q + 16'd1;
          end else if (rxd_i == 4'h5) begin
            rx_state_d = RX_PRE;
          end else begin
            rx_state_d = RX_DROP;
          end
        end
      end
      RX_PRE: begin
        rx_cnt_d = '0;
        if (!rx_ctl_i)           rx_state_d = RX_IDLE;
        else if (rxd_i == 4'hD)  rx_state_d = RX_DATA;
        else if (rxd_i != 4'h5)  rx_state_d = RX_DROP;
      end
      RX_DATA: begin
        if (!rx_ctl_i) begin
          rx_state_d = RX_IDLE;
          if (!rx_cnt_q[0] && rx_cnt_q != '0) begin
            rx_pend_d = 1'b1;
            rx_size_d = rx_cnt_q[cnt_width_lp-1:1];
          end
        end else if (!rx_cnt_q[0]) begin
          if (rx_cnt_q[cnt_width_lp-1:1] == size_width_lp'(buf_size_p)) begin
            rx_state_d = RX_DROP;
          end else begin
            rx_lo_d  = rxd_i;
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end else begin
          rx_we    = 1'b1;
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: if (!rx_ctl_i) rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_inten_d = rx_inten_q;
    tx_inten_d = tx_inten_q;
    tx_size_d  = tx_size_q;
    tmp_size   = merge(32'(tx_size_q), wshift, wmask);
    tmp_en     = merge(32'(host_wr && reg_word == tx_inten_addr_lp ? tx_inten_q : rx_inten_q),
                       wshift, wmask);
    if (host_wr && !in_rx && !in_tx) begin
      if (reg_word == tx_size_addr_lp)  tx_size_d  = tmp_size[size_width_lp-1:0];
      if (reg_word == rx_inten_addr_lp) rx_inten_d = tmp_en[0];
      if (reg_word == tx_inten_addr_lp) tx_inten_d = tmp_en[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (host_wr && in_tx) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) tx_mem[addr_i[off_width_lp-1:2]][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
    if (rx_we) rx_mem[rx_off[off_width_lp-1:2]][{rx_off[1:0], 3'b000} +: 8] <= rx_byte;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state_q  <= TX_IDLE;
      rx_state_q  <= RX_IDLE;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      tx_len_q    <= '0;
      tx_size_q   <= '0;
      rx_size_q   <= '0;
      rx_drop_q   <= '0;
      rx_lo_q     <= '0;
      rx_pend_q   <= 1'b0;
      rx_inten_q  <= 1'b0;
      tx_pend_q   <= 1'b0;
      tx_inten_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_len_q    <= tx_len_d;
      tx_size_q   <= tx_size_d;
      rx_size_q   <= rx_size_d;
      rx_drop_q   <= rx_drop_d;
      rx_lo_q     <= rx_lo_d;
      rx_pend_q   <= rx_pend_d;
      rx_inten_q  <= rx_inten_d;
      tx_pend_q   <= tx_pend_d;
      tx_inten_q  <= tx_inten_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data_o            = read_data_q;
  assign rx_interrupt_pending_o = rx_pend_q & rx_inten_q;
  assign tx_interrupt_pending_o = tx_pend_q & tx_inten_q;

endmodule

// File: tb/tb_eth_mac_mmio.sv
// tb/tb_eth_mac_mmio.sv - loopback pair bench: instance a transmits into instance b
module tb_eth_mac_mmio;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [15:0] a_addr, b_addr;
  logic        a_we, a_re, b_we, b_re;
  logic [1:0]  a_size, b_size;
  logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_rxi, a_txi, b_rxi, b_txi;
  logic [3:0]  a_txd, b_txd;
  logic        a_txctl, b_txctl;

  int n_checks = 0;
  int n_fail   = 0;
  int ctl_cnt  = 0;

  eth_mac_mmio u_a (
    .clk_i(clk), .reset_n_i(rst_a), .addr_i(a_addr), .write_en_i(a_we), .read_en_i(a_re),
    .op_size_i(a_size), .write_data_i(a_wdata), .read_data_o(a_rdata),
    .rx_interrupt_pending_o(a_rxi), .tx_interrupt_pending_o(a_txi),
    .rxd_i(b_txd), .rx_ctl_i(b_txctl), .txd_o(a_txd), .tx_ctl_o(a_txctl)
  );

  eth_mac_mmio u_b (
    .clk_i(clk), .reset_n_i(rst_b), .addr_i(b_addr), .write_en_i(b_we), .read_en_i(b_re),
    .op_size_i(b_size), .write_data_i(b_wdata), .read_data_o(b_rdata),
    .rx_interrupt_pending_o(b_rxi), .tx_interrupt_pending_o(b_txi),
    .rxd_i(a_txd), .rx_ctl_i(a_txctl), .txd_o(b_txd), .tx_ctl_o(b_txctl)
  );

  always @(negedge clk) if (a_txctl) ctl_cnt <= ctl_cnt + 1;

  typedef struct {
    bit          inst;
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  sz;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic hw(input bit inst, input logic [15:0] addr, input logic [1:0] sz,
                    input logic [31:0] d);
    @(negedge clk);
    if (inst) begin b_addr = addr; b_size = sz; b_wdata = d; b_we = 1'b1; end
    else      begin a_addr = addr; a_size = sz; a_wdata = d; a_we = 1'b1; end
    @(negedge clk);
    a_we = 1'b0;
    b_we = 1'b0;
  endtask

  task automatic hr(input bit inst, input logic [15:0] addr, input logic [1:0] sz,
                    output logic [31:0] d);
    @(negedge clk);
    if (inst) begin b_addr = addr; b_size = sz; b_re = 1'b1; end
    else      begin a_addr = addr; a_size = sz; a_re = 1'b1; end
    @(negedge clk);
    a_re = 1'b0;
    b_re = 1'b0;
    d = inst ? b_rdata : a_rdata;
  endtask

  task automatic rd_chk(input bit inst, input logic [15:0] addr, input logic [1:0] sz,
                        input logic [31:0] exp, input string name);
    logic [31:0] d;
    hr(inst, addr, sz, d);
    check(name, d, exp);
  endtask

  task automatic wait_ready();
    logic [31:0] d;
    d = 32'h0;
    for (int i = 0; i < 400; i++) begin
      hr(1'b0, 16'h101C, 2'd2, d);
      if (d == 32'h1) break;
    end
    check("tx_ready_wait", d, 32'h1);
  endtask

  task automatic wait_txi();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (a_txi) break;
    end
    check("tx_irq_wait", {31'h0, a_txi}, 32'h1);
  endtask

  task automatic send_frame(input logic [31:0] size);
    hw(1'b0, 16'h1028, 2'd2, size);
    hw(1'b0, 16'h1018, 2'd2, 32'h1);
    wait_txi();
    hw(1'b0, 16'h1030, 2'd2, 32'h1);
    wait_ready();
  endtask

  initial begin
    int s, n, data_nib;
    logic [31:0] exp;
    logic exp_pend;
    int delays[2];

    rst_a = 1'b0; rst_b = 1'b0;
    a_addr = '0; b_addr = '0; a_we = 0; b_we = 0; a_re = 0; b_re = 0;
    a_size = '0; b_size = '0; a_wdata = '0; b_wdata = '0;

    vecs[0]  = '{1'b0, 1'b0, 16'h101C, 2'd2, 32'h1,        "tx_ready_rst"};
    vecs[1]  = '{1'b0, 1'b0, 16'h1010, 2'd2, 32'h0,        "rx_pend_rst"};
    vecs[2]  = '{1'b0, 1'b0, 16'h1004, 2'd2, 32'h0,        "rx_size_rst"};
    vecs[3]  = '{1'b1, 1'b0, 16'h1008, 2'd2, 32'h0,        "drop_cnt_rst"};
    vecs[4]  = '{1'b0, 1'b1, 16'h1034, 2'd2, 32'h1,        ""};
    vecs[5]  = '{1'b0, 1'b0, 16'h1034, 2'd2, 32'h1,        "tx_int_en_rb"};
    vecs[6]  = '{1'b0, 1'b1, 16'h1028, 2'd2, 32'h0000FABC, ""};
    vecs[7]  = '{1'b0, 1'b0, 16'h1028, 2'd2, 32'h0ABC,     "tx_size_rb"};
    vecs[8]  = '{1'b0, 1'b0, 16'h1028, 2'd0, 32'hBC,       "tx_size_byte0"};
    vecs[9]  = '{1'b0, 1'b0, 16'h1029, 2'd0, 32'h0A,       "tx_size_byte1"};
    vecs[10] = '{1'b0, 1'b0, 16'h102A, 2'd2, 32'h0,        "misaligned_rd"};
    vecs[11] = '{1'b0, 1'b0, 16'h1028, 2'd3, 32'h0,        "op3_rd"};
    vecs[12] = '{1'b0, 1'b0, 16'h1040, 2'd2, 32'h0,        "unmapped_rd"};
    vecs[13] = '{1'b0, 1'b0, 16'h0800, 2'd2, 32'h0,        "tx_buf_rd"};
    vecs[14] = '{1'b0, 1'b1, 16'h1036, 2'd0, 32'h0,        ""};
    vecs[15] = '{1'b0, 1'b0, 16'h1034, 2'd2, 32'h1,        "narrow_wr_other_lane"};

    repeat (3) @(negedge clk);
    check("txd_rst", {28'h0, a_txd}, 32'h0);
    check("txctl_rst", {31'h0, a_txctl}, 32'h0);
    check("irq_rst", {30'h0, b_rxi, a_txi}, 32'h0);
    rst_a = 1'b1; rst_b = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) hw(vecs[i].inst, vecs[i].addr, vecs[i].sz, vecs[i].data);
      else rd_chk(vecs[i].inst, vecs[i].addr, vecs[i].sz, vecs[i].data, vecs[i].name);
    end

    // 64-byte loopback frame
    for (int i = 0; i < 16; i++)
      hw(1'b0, 16'h0800 + 16'(4 * i), 2'd2,
         {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
    hw(1'b0, 16'h1028, 2'd2, 32'd64);
    s = ctl_cnt;
    hw(1'b0, 16'h1018, 2'd2, 32'h0);
    rd_chk(1'b0, 16'h101C, 2'd2, 32'h0, "tx_busy");
    wait_txi();
    check("tx_ctl_cycles", ctl_cnt - s, 32'd144);
    rd_chk(1'b0, 16'h1030, 2'd2, 32'h1, "tx_pend_set");
    hw(1'b0, 16'h1030, 2'd2, 32'h1);
    check("tx_irq_clr", {31'h0, a_txi}, 32'h0);
    wait_ready();
    rd_chk(1'b1, 16'h1010, 2'd2, 32'h1, "rx_pend");
    rd_chk(1'b1, 16'h1004, 2'd2, 32'd64, "rx_size64");
    for (int i = 0; i < 16; i++)
      rd_chk(1'b1, 16'(4 * i), 2'd2,
             {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)}, "rx_word");

    // 66-byte frame, narrow reads
    hw(1'b1, 16'h1010, 2'd2, 32'h1);
    hw(1'b0, 16'h0840, 2'd2, 32'h43424140);
    send_frame(32'd66);
    rd_chk(1'b1, 16'h1004, 2'd2, 32'd66, "rx_size66");
    rd_chk(1'b1, 16'h0040, 2'd1, 32'h4140, "narrow_rd_2b");
    rd_chk(1'b1, 16'h0041, 2'd0, 32'h41, "narrow_rd_1b");
    rd_chk(1'b1, 16'h0041, 2'd1, 32'h0, "misaligned_2b");

    // Overrun: second frame arrives while the first is held
    hw(1'b0, 16'h0800, 2'd2, 32'hDEADBEEF);
    send_frame(32'd8);
    rd_chk(1'b1, 16'h1008, 2'd2, 32'd1, "drop_cnt");
    rd_chk(1'b1, 16'h1004, 2'd2, 32'd66, "first_size_kept");
    rd_chk(1'b1, 16'h0000, 2'd2, 32'h03020100, "first_data_kept");
    hw(1'b1, 16'h1014, 2'd2, 32'h1);
    check("rx_irq_on", {31'h0, b_rxi}, 32'h1);
    hw(1'b1, 16'h1010, 2'd2, 32'h1);
    check("rx_irq_off", {31'h0, b_rxi}, 32'h0);
    rd_chk(1'b1, 16'h1010, 2'd2, 32'h0, "rx_pend_clr");

    // Invalid sends and write masking
    hw(1'b0, 16'h1028, 2'd2, 32'd0);
    s = ctl_cnt;
    hw(1'b0, 16'h1018, 2'd2, 32'h1);
    repeat (30) @(negedge clk);
    check("size0_no_tx", ctl_cnt - s, 32'd0);
    rd_chk(1'b0, 16'h101C, 2'd2, 32'h1, "size0_ready");
    hw(1'b0, 16'h1028, 2'd2, 32'd2049);
    hw(1'b0, 16'h1018, 2'd2, 32'h1);
    repeat (30) @(negedge clk);
    check("size2049_no_tx", ctl_cnt - s, 32'd0);
    rd_chk(1'b0, 16'h101C, 2'd2, 32'h1, "size2049_ready");
    hw(1'b0, 16'h0802, 2'd2, 32'hFFFFFFFF);
    hw(1'b0, 16'h0801, 2'd0, 32'h00000077);
    send_frame(32'd4);
    rd_chk(1'b1, 16'h1004, 2'd2, 32'd4, "rx_size4");
    rd_chk(1'b1, 16'h0000, 2'd2, 32'hDEAD77EF, "tx_wr_mask");

    // Reset mid-transmit, one even and one odd payload cut
    delays[0] = 40;
    delays[1] = 41;
    for (int k = 0; k < 2; k++) begin
      hw(1'b1, 16'h1010, 2'd2, 32'h1);
      hw(1'b0, 16'h1028, 2'd2, 32'd64);
      s = ctl_cnt;
      hw(1'b0, 16'h1018, 2'd2, 32'h1);
      for (int i = 0; i < 50; i++) begin
        if (a_txctl) break;
        @(negedge clk);
      end
      check("tx_start", {31'h0, a_txctl}, 32'h1);
      repeat (delays[k]) @(posedge clk);
      #1 rst_a = 1'b0;
      #1 check("txctl_async_rst", {31'h0, a_txctl}, 32'h0);
      repeat (4) @(negedge clk);
      rst_a = 1'b1;
      n = ctl_cnt - s;
      data_nib = n - 16;
      exp_pend = (data_nib >= 2) && (data_nib % 2 == 0);
      rd_chk(1'b1, 16'h1010, 2'd2, {31'h0, exp_pend}, "trunc_pend");
      if (exp_pend) rd_chk(1'b1, 16'h1004, 2'd2, 32'(data_nib / 2), "trunc_size");
      rd_chk(1'b0, 16'h101C, 2'd2, 32'h1, "a_ready_after_rst");
      rd_chk(1'b0, 16'h1028, 2'd2, 32'h0, "a_size_after_rst");
    end
    exp = 32'd24;
    check("trunc_even_nibbles", 32'(delays[0] - 16), exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
